// File: rtl/mem_wb_load_stage_pkg.sv
// Shared widths, memory-select encodings and writeback FSM states for the MEM->WB load stage.
package mem_wb_load_stage_pkg;

  localparam int DATA_BUS     = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int ADDR_BUS     = 32;

  localparam logic [3:0] MEM_SEL_BYTE = 4'b0001;
  localparam logic [3:0] MEM_SEL_HALF = 4'b0011;
  localparam logic [3:0] MEM_SEL_WORD = 4'b1111;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_WAIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/mem_wb_load_stage_if.sv
// MEM-side inputs, RAM response and writeback outputs of the MEM->WB load stage.
interface mem_wb_load_stage_if;
  import mem_wb_load_stage_pkg::*;

  logic                    flush;
  logic                    mem_read_flag;
  logic                    mem_write_flag;
  logic                    mem_sign_ext_flag;
  logic [3:0]              mem_sel;
  logic [DATA_BUS-1:0]     result;
  logic                    write_reg_en;
  logic [REG_ADDR_BUS-1:0] write_reg_addr;
  logic                    hilo_write_en;
  logic [DATA_BUS-1:0]     hi;
  logic [DATA_BUS-1:0]     lo;
  logic [ADDR_BUS-1:0]     debug_pc_addr;
  logic [DATA_BUS-1:0]     ram_rdata;
  logic                    ram_rvalid;

  logic                    stall_req;
  logic                    wb_reg_en;
  logic [REG_ADDR_BUS-1:0] wb_reg_addr;
  logic [DATA_BUS-1:0]     wb_reg_data;
  logic                    wb_hilo_en;
  logic [DATA_BUS-1:0]     wb_hi;
  logic [DATA_BUS-1:0]     wb_lo;
  logic                    load_err;
  logic [ADDR_BUS-1:0]     debug_wb_pc;
  logic [3:0]              debug_wb_rf_wen;

  modport master (
    output flush, mem_read_flag, mem_write_flag, mem_sign_ext_flag, mem_sel, result,
           write_reg_en, write_reg_addr, hilo_write_en, hi, lo, debug_pc_addr,
           ram_rdata, ram_rvalid,
    input  stall_req, wb_reg_en, wb_reg_addr, wb_reg_data, wb_hilo_en, wb_hi, wb_lo,
           load_err, debug_wb_pc, debug_wb_rf_wen
  );

  modport slave (
    input  flush, mem_read_flag, mem_write_flag, mem_sign_ext_flag, mem_sel, result,
           write_reg_en, write_reg_addr, hilo_write_en, hi, lo, debug_pc_addr,
           ram_rdata, ram_rvalid,
    output stall_req, wb_reg_en, wb_reg_addr, wb_reg_data, wb_hilo_en, wb_hi, wb_lo,
           load_err, debug_wb_pc, debug_wb_rf_wen
  );

endinterface

// File: rtl/mem_wb_load_stage_load_aligner.sv
// Extracts the byte/half/word lane from a word-aligned read and sign- or zero-extends it.
module load_aligner
  import mem_wb_load_stage_pkg::*;
(
  input  logic [DATA_BUS-1:0] rdata,
  input  logic [1:0]          addr,
  input  logic [3:0]          sel,
  input  logic                sign_ext,
  output logic [DATA_BUS-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Misaligned halves/words and unknown selects deliberately return zero.
  always_comb begin
    data   = '0;
    byte_v = rdata[{addr, 3'b000} +: 8];
    half_v = rdata[{addr[1], 4'b0000} +: 16];
    case (sel)
      MEM_SEL_BYTE: data = {{24{sign_ext & byte_v[7]}}, byte_v};
      MEM_SEL_HALF: begin
        if (!addr[0]) begin
          data = {{16{sign_ext & half_v[15]}}, half_v};
        end
      end
      MEM_SEL_WORD: begin
        if (addr == 2'b00) begin
          data = rdata;
        end
      end
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_wb_load_stage.sv
// MEM->WB pipeline register: passes ALU results through and waits on RAM for loads.
module mem_wb_load_stage
  import mem_wb_load_stage_pkg::*;
#(
  parameter int RESP_TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  mem_wb_load_stage_if.slave bus
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(RESP_TIMEOUT - 1);

  wb_state_e               state_q, state_d;
  logic [7:0]              wait_cnt_q, wait_cnt_d;

  logic [1:0]              held_addr_q, held_addr_d;
  logic [3:0]              held_sel_q, held_sel_d;
  logic                    held_sign_q, held_sign_d;
  logic                    held_reg_en_q, held_reg_en_d;
  logic [REG_ADDR_BUS-1:0] held_reg_addr_q, held_reg_addr_d;
  logic [ADDR_BUS-1:0]     held_pc_q, held_pc_d;

  logic                    wb_reg_en_q, wb_reg_en_d;
  logic [REG_ADDR_BUS-1:0] wb_reg_addr_q, wb_reg_addr_d;
  logic [DATA_BUS-1:0]     wb_reg_data_q, wb_reg_data_d;
  logic                    wb_hilo_en_q, wb_hilo_en_d;
  logic [DATA_BUS-1:0]     wb_hi_q, wb_hi_d;
  logic [DATA_BUS-1:0]     wb_lo_q, wb_lo_d;
  logic                    load_err_q, load_err_d;
  logic [ADDR_BUS-1:0]     debug_wb_pc_q, debug_wb_pc_d;

  logic                    is_load;
  logic [DATA_BUS-1:0]     aligned_data;

  assign is_load = bus.mem_read_flag & ~bus.mem_write_flag;

  load_aligner u_load_aligner (
    .rdata    (bus.ram_rdata),
    .addr     (held_addr_q),
    .sel      (held_sel_q),
    .sign_ext (held_sign_q),
    .data     (aligned_data)
  );

  // Write pulses default low; data/address/PC outputs hold until the next writeback.
  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    held_addr_d     = held_addr_q;
    held_sel_d      = held_sel_q;
    held_sign_d     = held_sign_q;
    held_reg_en_d   = held_reg_en_q;
    held_reg_addr_d = held_reg_addr_q;
    held_pc_d       = held_pc_q;
    wb_reg_en_d     = 1'b0;
    wb_reg_addr_d   = wb_reg_addr_q;
    wb_reg_data_d   = wb_reg_data_q;
    wb_hilo_en_d    = 1'b0;
    wb_hi_d         = wb_hi_q;
    wb_lo_d         = wb_lo_q;
    load_err_d      = 1'b0;
    debug_wb_pc_d   = debug_wb_pc_q;

    if (bus.flush) begin
      state_d         = WB_IDLE;
      wait_cnt_d      = '0;
      held_addr_d     = '0;
      held_sel_d      = '0;
      held_sign_d     = 1'b0;
      held_reg_en_d   = 1'b0;
      held_reg_addr_d = '0;
      held_pc_d       = '0;
    end else begin
      case (state_q)
        WB_IDLE: begin
          if (is_load) begin
            held_addr_d     = bus.result[1:0];
            held_sel_d      = bus.mem_sel;
            held_sign_d     = bus.mem_sign_ext_flag;
            held_reg_en_d   = bus.write_reg_en;
            held_reg_addr_d = bus.write_reg_addr;
            held_pc_d       = bus.debug_pc_addr;
            wait_cnt_d      = '0;
            state_d         = WB_WAIT;
          end else begin
            wb_reg_en_d   = bus.write_reg_en;
            wb_reg_addr_d = bus.write_reg_addr;
            wb_reg_data_d = bus.result;
            wb_hilo_en_d  = bus.hilo_write_en;
            wb_hi_d       = bus.hi;
            wb_lo_d       = bus.lo;
            debug_wb_pc_d = bus.debug_pc_addr;
          end
        end
        WB_WAIT: begin
          if (bus.ram_rvalid || (wait_cnt_q == TIMEOUT_LAST)) begin
            wb_reg_en_d     = held_reg_en_q;
            wb_reg_addr_d   = held_reg_addr_q;
            wb_reg_data_d   = bus.ram_rvalid ? aligned_data : '0;
            load_err_d      = ~bus.ram_rvalid;
            debug_wb_pc_d   = held_pc_q;
            state_d         = WB_IDLE;
            wait_cnt_d      = '0;
            held_reg_en_d   = 1'b0;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
        default: state_d = WB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= WB_IDLE;
      wait_cnt_q      <= '0;
      held_addr_q     <= '0;
      held_sel_q      <= '0;
      held_sign_q     <= 1'b0;
      held_reg_en_q   <= 1'b0;
      held_reg_addr_q <= '0;
      held_pc_q       <= '0;
      wb_reg_en_q     <= 1'b0;
      wb_reg_addr_q   <= '0;
      wb_reg_data_q   <= '0;
      wb_hilo_en_q    <= 1'b0;
      wb_hi_q         <= '0;
      wb_lo_q         <= '0;
      load_err_q      <= 1'b0;
      debug_wb_pc_q   <= '0;
    end else begin
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      held_addr_q     <= held_addr_d;
      held_sel_q      <= held_sel_d;
      held_sign_q     <= held_sign_d;
      held_reg_en_q   <= held_reg_en_d;
      held_reg_addr_q <= held_reg_addr_d;
      held_pc_q       <= held_pc_d;
      wb_reg_en_q     <= wb_reg_en_d;
      wb_reg_addr_q   <= wb_reg_addr_d;
      wb_reg_data_q   <= wb_reg_data_d;
      wb_hilo_en_q    <= wb_hilo_en_d;
      wb_hi_q         <= wb_hi_d;
      wb_lo_q         <= wb_lo_d;
      load_err_q      <= load_err_d;
      debug_wb_pc_q   <= debug_wb_pc_d;
    end
  end

  assign bus.stall_req       = (state_q == WB_WAIT);
  assign bus.wb_reg_en       = wb_reg_en_q;
  assign bus.wb_reg_addr     = wb_reg_addr_q;
  assign bus.wb_reg_data     = wb_reg_data_q;
  assign bus.wb_hilo_en      = wb_hilo_en_q;
  assign bus.wb_hi           = wb_hi_q;
  assign bus.wb_lo           = wb_lo_q;
  assign bus.load_err        = load_err_q;
  assign bus.debug_wb_pc     = debug_wb_pc_q;
  assign bus.debug_wb_rf_wen = {4{wb_reg_en_q}};

endmodule

// File: tb/tb_mem_wb_load_stage.sv
// Scoreboard bench for mem_wb_load_stage: tasks queue expected writebacks, a monitor checks them.
module tb_mem_wb_load_stage;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic        reg_en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        hilo_en;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] pc;
    logic        err;
  } wb_exp_t;

  wb_exp_t sb_q[$];
  wb_exp_t mon_exp;

  mem_wb_load_stage_if bus ();

  mem_wb_load_stage #(.RESP_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every write pulse or load error must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (bus.wb_reg_en || bus.wb_hilo_en || bus.load_err)) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_wb: got reg_en=%b hilo_en=%b err=%b pc=%h, required no writeback",
                 bus.wb_reg_en, bus.wb_hilo_en, bus.load_err, bus.debug_wb_pc);
      end else begin
        mon_exp = sb_q.pop_front();
        if (bus.wb_reg_en !== mon_exp.reg_en || bus.wb_hilo_en !== mon_exp.hilo_en ||
            bus.load_err !== mon_exp.err || bus.debug_wb_pc !== mon_exp.pc ||
            (mon_exp.reg_en && (bus.wb_reg_addr !== mon_exp.addr || bus.wb_reg_data !== mon_exp.data)) ||
            (mon_exp.hilo_en && (bus.wb_hi !== mon_exp.hi || bus.wb_lo !== mon_exp.lo))) begin
          errors++;
          $display("[TB] FAIL wb_event: got en=%b hilo=%b err=%b addr=%0d data=%h hi=%h lo=%h pc=%h, required en=%b hilo=%b err=%b addr=%0d data=%h hi=%h lo=%h pc=%h",
                   bus.wb_reg_en, bus.wb_hilo_en, bus.load_err, bus.wb_reg_addr, bus.wb_reg_data,
                   bus.wb_hi, bus.wb_lo, bus.debug_wb_pc, mon_exp.reg_en, mon_exp.hilo_en, mon_exp.err,
                   mon_exp.addr, mon_exp.data, mon_exp.hi, mon_exp.lo, mon_exp.pc);
        end
      end
    end
  end

  task automatic set_idle();
    bus.flush             = 1'b0;
    bus.mem_read_flag     = 1'b0;
    bus.mem_write_flag    = 1'b0;
    bus.mem_sign_ext_flag = 1'b0;
    bus.mem_sel           = 4'b0000;
    bus.result            = 32'h0;
    bus.write_reg_en      = 1'b0;
    bus.write_reg_addr    = 5'd0;
    bus.hilo_write_en     = 1'b0;
    bus.hi                = 32'h0;
    bus.lo                = 32'h0;
    bus.debug_pc_addr     = 32'h0;
    bus.ram_rdata         = 32'hDEAD_BEEF;
    bus.ram_rvalid        = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic reg_en, input logic [4:0] addr, input logic [31:0] data,
                           input logic hilo_en, input logic [31:0] hi, input logic [31:0] lo,
                           input logic [31:0] pc, input logic store);
    wb_exp_t e;
    bus.mem_read_flag  = 1'b0;
    bus.mem_write_flag = store;
    bus.mem_sel        = store ? 4'b1111 : 4'b0000;
    bus.write_reg_en   = reg_en;
    bus.write_reg_addr = addr;
    bus.result         = data;
    bus.hilo_write_en  = hilo_en;
    bus.hi             = hi;
    bus.lo             = lo;
    bus.debug_pc_addr  = pc;
    if (reg_en || hilo_en) begin
      e = '{reg_en: reg_en, addr: addr, data: data, hilo_en: hilo_en, hi: hi, lo: lo, pc: pc, err: 1'b0};
      sb_q.push_back(e);
    end
  endtask

  task automatic drive_load(input logic sext, input logic [3:0] sel, input logic [31:0] addr,
                            input logic [4:0] reg_addr, input logic [31:0] pc);
    bus.mem_read_flag     = 1'b1;
    bus.mem_write_flag    = 1'b0;
    bus.mem_sign_ext_flag = sext;
    bus.mem_sel           = sel;
    bus.result            = addr;
    bus.write_reg_en      = 1'b1;
    bus.write_reg_addr    = reg_addr;
    bus.hilo_write_en     = 1'b0;
    bus.debug_pc_addr     = pc;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drain: got %0d pending writebacks, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  // lat = number of WAIT cycles, the last one carrying ram_rvalid.
  task automatic run_load(input string name, input logic sext, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] rdata, input int lat,
                          input logic [31:0] exp_data);
    wb_exp_t e;
    int      stall_cnt;
    logic [31:0] pc;
    pc = 32'h8000_0000 | addr;
    e = '{reg_en: 1'b1, addr: 5'd7, data: exp_data, hilo_en: 1'b0, hi: 32'h0, lo: 32'h0, pc: pc, err: 1'b0};
    sb_q.push_back(e);
    drive_load(sext, sel, addr, 5'd7, pc);
    next_cycle();
    set_idle();
    stall_cnt = 0;
    for (int i = 0; i < lat; i++) begin
      if (i == lat - 1) begin
        bus.ram_rvalid = 1'b1;
        bus.ram_rdata  = rdata;
      end
      @(negedge clk);
      if (bus.stall_req === 1'b1) stall_cnt++;
      next_cycle();
      bus.ram_rvalid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (stall_cnt != lat || bus.stall_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_stall: got %0d stall cycles, stall_req now %b, required %0d and 0",
               name, stall_cnt, bus.stall_req, lat);
    end
    next_cycle();
    check_drained(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.stall_req !== 1'b0 || bus.wb_reg_en !== 1'b0 || bus.wb_reg_data !== 32'h0 ||
        bus.wb_hilo_en !== 1'b0 || bus.load_err !== 1'b0 || bus.debug_wb_pc !== 32'h0 ||
        bus.debug_wb_rf_wen !== 4'h0 || bus.wb_hi !== 32'h0 || bus.wb_lo !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: got stall=%b en=%b data=%h pc=%h, required all zero",
               bus.stall_req, bus.wb_reg_en, bus.wb_reg_data, bus.debug_wb_pc);
    end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_alu();
    drive_alu(1'b1, 5'd5, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 32'hBFC0_0000, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.stall_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL alu_stall_before: got %b, required 0", bus.stall_req);
    end
    next_cycle();
    set_idle();
    @(negedge clk);
    checks++;
    if (bus.wb_reg_en !== 1'b1 || bus.wb_reg_addr !== 5'd5 || bus.wb_reg_data !== 32'h1234_5678 ||
        bus.debug_wb_rf_wen !== 4'hF || bus.stall_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL alu_wb: got en=%b addr=%0d data=%h wen=%h stall=%b, required 1 5 12345678 f 0",
               bus.wb_reg_en, bus.wb_reg_addr, bus.wb_reg_data, bus.debug_wb_rf_wen, bus.stall_req);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.wb_reg_en !== 1'b0 || bus.debug_wb_rf_wen !== 4'h0) begin
      errors++;
      $display("[TB] FAIL alu_pulse: got en=%b wen=%h, required 0 0", bus.wb_reg_en, bus.debug_wb_rf_wen);
    end
    next_cycle();
    check_drained("alu");
  endtask

  task automatic test_hilo_store();
    drive_alu(1'b0, 5'd0, 32'h0, 1'b1, 32'hAAAA_0001, 32'h5555_0002, 32'hBFC0_0010, 1'b0);
    next_cycle();
    drive_alu(1'b0, 5'd3, 32'h0000_1000, 1'b0, 32'h0, 32'h0, 32'hBFC0_0014, 1'b1);
    next_cycle();
    set_idle();
    @(negedge clk);
    checks++;
    if (bus.wb_reg_en !== 1'b0 || bus.wb_hilo_en !== 1'b0 || bus.debug_wb_pc !== 32'hBFC0_0014) begin
      errors++;
      $display("[TB] FAIL store_pass: got en=%b hilo=%b pc=%h, required 0 0 bfc00014",
               bus.wb_reg_en, bus.wb_hilo_en, bus.debug_wb_pc);
    end
    next_cycle();
    check_drained("hilo_store");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive_alu(1'b1, 5'(i + 10), $urandom, 1'(i & 1), $urandom, $urandom, 32'hBFC0_0100 + 32'(4 * i), 1'b0);
      next_cycle();
    end
    set_idle();
    repeat (2) next_cycle();
    check_drained("back_to_back");
  endtask

  task automatic test_loads();
    run_load("lb_sign", 1'b1, 4'b0001, 32'h0000_0103, 32'h80FF_FF7F, 2, 32'hFFFF_FF80);
    run_load("lbu", 1'b0, 4'b0001, 32'h0000_0103, 32'h80FF_FF7F, 2, 32'h0000_0080);
    run_load("lb_lane0", 1'b1, 4'b0001, 32'h0000_0200, 32'h80FF_FF7F, 3, 32'h0000_007F);
    run_load("lh_sign", 1'b1, 4'b0011, 32'h0000_0002, 32'h8001_1234, 1, 32'hFFFF_8001);
    run_load("lh_odd", 1'b1, 4'b0011, 32'h0000_0001, 32'h8001_1234, 1, 32'h0000_0000);
    run_load("lhu_low", 1'b0, 4'b0011, 32'h0000_0000, 32'h8001_9234, 2, 32'h0000_9234);
    run_load("lw", 1'b1, 4'b1111, 32'h0000_0010, 32'hCAFE_F00D, 4, 32'hCAFE_F00D);
    run_load("lw_mis", 1'b1, 4'b1111, 32'h0000_0012, 32'hCAFE_F00D, 1, 32'h0000_0000);
    run_load("bad_sel", 1'b1, 4'b0101, 32'h0000_0000, 32'hCAFE_F00D, 1, 32'h0000_0000);
  endtask

  task automatic test_timeout();
    wb_exp_t e;
    int      stall_cnt;
    e = '{reg_en: 1'b1, addr: 5'd9, data: 32'h0, hilo_en: 1'b0, hi: 32'h0, lo: 32'h0, pc: 32'hBFC0_0200, err: 1'b1};
    sb_q.push_back(e);
    drive_load(1'b1, 4'b1111, 32'h0000_0040, 5'd9, 32'hBFC0_0200);
    next_cycle();
    set_idle();
    stall_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.stall_req === 1'b1) stall_cnt++;
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (stall_cnt != 4 || bus.stall_req !== 1'b0 || bus.load_err !== 1'b1 || bus.wb_reg_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL timeout: got stalls=%0d stall=%b err=%b data=%h, required 4 0 1 0",
               stall_cnt, bus.stall_req, bus.load_err, bus.wb_reg_data);
    end
    next_cycle();
    bus.ram_rvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.load_err !== 1'b0 || bus.stall_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_pulse: got err=%b stall=%b, required 0 0", bus.load_err, bus.stall_req);
    end
    next_cycle();
    bus.ram_rvalid = 1'b0;
    repeat (2) next_cycle();
    check_drained("timeout");
  endtask

  task automatic test_flush();
    drive_load(1'b1, 4'b1111, 32'h0000_0080, 5'd11, 32'hBFC0_0300);
    next_cycle();
    set_idle();
    bus.flush = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.stall_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_wait: got stall=%b, required 1", bus.stall_req);
    end
    next_cycle();
    bus.flush      = 1'b0;
    bus.ram_rvalid = 1'b1;
    bus.ram_rdata  = 32'h1111_2222;
    @(negedge clk);
    checks++;
    if (bus.stall_req !== 1'b0 || bus.wb_reg_en !== 1'b0 || bus.load_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_kill: got stall=%b en=%b err=%b, required 0 0 0",
               bus.stall_req, bus.wb_reg_en, bus.load_err);
    end
    next_cycle();
    bus.ram_rvalid = 1'b0;
    repeat (2) next_cycle();
    check_drained("flush");
  endtask

  task automatic test_bubble();
    wb_exp_t e;
    e = '{reg_en: 1'b1, addr: 5'd12, data: 32'h0000_0034, hilo_en: 1'b0, hi: 32'h0, lo: 32'h0, pc: 32'hBFC0_0400, err: 1'b0};
    sb_q.push_back(e);
    drive_load(1'b0, 4'b0001, 32'h0000_0001, 5'd12, 32'hBFC0_0400);
    next_cycle();
    bus.mem_read_flag  = 1'b0;
    bus.write_reg_en   = 1'b1;
    bus.write_reg_addr = 5'd13;
    bus.result         = 32'h7777_7777;
    bus.ram_rvalid     = 1'b1;
    bus.ram_rdata      = 32'h0000_3400;
    next_cycle();
    set_idle();
    @(negedge clk);
    checks++;
    if (bus.wb_reg_data !== 32'h0000_0034 || bus.wb_reg_addr !== 5'd12) begin
      errors++;
      $display("[TB] FAIL bubble: got addr=%0d data=%h, required 12 00000034", bus.wb_reg_addr, bus.wb_reg_data);
    end
    repeat (2) next_cycle();
    check_drained("bubble");
  endtask

  task automatic test_reset_mid_wait();
    drive_alu(1'b1, 5'd20, 32'h5A5A_5A5A, 1'b1, 32'h1, 32'h2, 32'hBFC0_0500, 1'b0);
    next_cycle();
    drive_load(1'b1, 4'b1111, 32'h0000_0000, 5'd21, 32'hBFC0_0504);
    next_cycle();
    set_idle();
    sb_q.delete();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    bus.ram_rvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.stall_req !== 1'b0 || bus.wb_reg_en !== 1'b0 || bus.wb_reg_addr !== 5'd0 ||
        bus.wb_reg_data !== 32'h0 || bus.wb_hi !== 32'h0 || bus.wb_lo !== 32'h0 ||
        bus.debug_wb_pc !== 32'h0 || bus.load_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_wait: got stall=%b en=%b addr=%0d data=%h hi=%h pc=%h, required all zero",
               bus.stall_req, bus.wb_reg_en, bus.wb_reg_addr, bus.wb_reg_data, bus.wb_hi, bus.debug_wb_pc);
    end
    next_cycle();
    bus.ram_rvalid = 1'b0;
    drive_alu(1'b1, 5'd22, 32'h0BAD_F00D, 1'b0, 32'h0, 32'h0, 32'hBFC0_0600, 1'b0);
    next_cycle();
    set_idle();
    @(negedge clk);
    checks++;
    if (bus.wb_reg_en !== 1'b1 || bus.wb_reg_data !== 32'h0BAD_F00D) begin
      errors++;
      $display("[TB] FAIL rst_then_alu: got en=%b data=%h, required 1 0badf00d", bus.wb_reg_en, bus.wb_reg_data);
    end
    next_cycle();
    check_drained("rst_mid_wait");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_hilo_store();
    test_back_to_back();
    test_loads();
    test_timeout();
    test_flush();
    test_bubble();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
